rtc_bus_scheduler: RTL and testbench

- Sequences the shared multiplexed RTC bus between the read-cycle engine and the write-cycle engine.
- Periodically scans six timekeeping registers (seconds, minutes, hours, date, month, year) into a time shadow via the read engine.
- Services user write requests between individual reads.
- Drives engine start strobes, the address/data presented to the bus mux, the bus-owner select, and a watchdog on engine completion.

---
 rtl/rtc_pkg.sv | 42 ++++
 rtl/rtc_interval_timer.sv | 30 +++
 rtl/rtc_bus_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_rtc_bus_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus scheduler.
//   state_t     : scheduler FSM states
//   ADDR_*      : RTC register addresses visited by a scan, in scan order
//   SCAN_LEN    : number of registers per scan
//   scan_addr() : scan index -> RTC register address
package rtc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ISSUE = 3'd1,
      ST_RD_WAIT  = 3'd2,
      ST_WR_ISSUE = 3'd3,
      ST_WR_WAIT  = 3'd4,
      ST_GAP      = 3'd5
   } state_t;

   localparam logic [7:0] ADDR_SEC   = 8'h00;
   localparam logic [7:0] ADDR_MIN   = 8'h02;
   localparam logic [7:0] ADDR_HOUR  = 8'h04;
   localparam logic [7:0] ADDR_DATE  = 8'h07;
   localparam logic [7:0] ADDR_MONTH = 8'h08;
   localparam logic [7:0] ADDR_YEAR  = 8'h09;

   localparam int unsigned SCAN_LEN  = 6;
   localparam logic [2:0]  SCAN_LAST = 3'(SCAN_LEN - 1);

   function automatic logic [7:0] scan_addr(input logic [2:0] idx);
      logic [7:0] a;
      a = ADDR_SEC;
      case (idx)
         3'd0:    a = ADDR_SEC;
         3'd1:    a = ADDR_MIN;
         3'd2:    a = ADDR_HOUR;
         3'd3:    a = ADDR_DATE;
         3'd4:    a = ADDR_MONTH;
         3'd5:    a = ADDR_YEAR;
         default: a = ADDR_SEC;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/rtc_interval_timer.sv
// Free-running down-counter that reloads at zero and pulses o_tick for the
// cycle it sits at zero. Counts only while i_en=1.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (loads LOAD_CYCLES-1)
//   i_en           : count enable
//   o_tick         : one-cycle terminal pulse, every LOAD_CYCLES enabled cycles
module rtc_interval_timer #(
   parameter int unsigned LOAD_CYCLES = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_tick
);

   localparam int unsigned CW = (LOAD_CYCLES > 2) ? $clog2(LOAD_CYCLES) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(LOAD_CYCLES - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= RELOAD;
      end else if (i_en) begin
         r_cnt <= (r_cnt == '0) ? RELOAD : r_cnt - 1'b1;
      end
   end

   assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Arbitrates the shared RTC bus between the read and write cycle engines.
// Periodically scans six timekeeping registers into a time shadow and slots
// user writes in between individual reads; a watchdog bounds every wait.
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_enable               : scheduler enable
//   i_wr_req/addr/data     : user write request (level, held until o_wr_ack)
//   o_wr_ack               : one-cycle pulse, write finished or aborted
//   o_rd_start, i_rd_end   : read engine start / done, i_rd_data_in valid with done
//   o_wr_start, i_wr_end   : write engine start / done
//   o_bus_sel              : 0 = read engine owns bus, 1 = write engine
//   o_addr_out/o_wdata_out : address / write data to the bus mux
//   o_time_we/idx/data     : time shadow write port
//   o_scan_done            : one-cycle pulse with the last shadow write of a scan
//   o_timeout_err, i_err_clr : sticky watchdog flag and its clear
module rtc_bus_scheduler
   import rtc_pkg::*;
#(
   parameter int unsigned REFRESH_CYCLES = 1000000,
   parameter int unsigned GAP_CYCLES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_enable,
   input  logic       i_wr_req,
   input  logic [7:0] i_wr_addr,
   input  logic [7:0] i_wr_data,
   output logic       o_wr_ack,
   output logic       o_rd_start,
   input  logic       i_rd_end,
   input  logic [7:0] i_rd_data_in,
   output logic       o_wr_start,
   input  logic       i_wr_end,
   output logic       o_bus_sel,
   output logic [7:0] o_addr_out,
   output logic [7:0] o_wdata_out,
   output logic       o_time_we,
   output logic [2:0] o_time_idx,
   output logic [7:0] o_time_data,
   output logic       o_scan_done,
   output logic       o_timeout_err,
   input  logic       i_err_clr
);

   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned WW = $clog2(TIMEOUT_CYCLES);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_idx;
   logic        r_pending;
   logic [GW-1:0] r_gap;
   logic [WW-1:0] r_wdog;
   logic        r_bus_sel;
   logic [7:0]  r_addr;
   logic [7:0]  r_wdata;
   logic        r_time_we;
   logic [2:0]  r_time_idx;
   logic [7:0]  r_time_data;
   logic        r_scan_done;
   logic        r_wr_ack;
   logic        r_err;

   logic w_tick;
   logic w_timeout;
   logic w_rd_done;
   logic w_rd_abort;
   logic w_wr_fin;
   logic w_gap_done;
   logic w_last;

   rtc_interval_timer #(
      .LOAD_CYCLES(REFRESH_CYCLES)
   ) u_refresh (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_en   (i_enable),
      .o_tick (w_tick)
   );

   // An end pulse landing on the final watchdog cycle counts as completion.
   assign w_timeout  = (r_wdog == WD_LAST) &&
                       (((r_state == ST_RD_WAIT) && !i_rd_end) ||
                        ((r_state == ST_WR_WAIT) && !i_wr_end));
   assign w_rd_done  = (r_state == ST_RD_WAIT) && i_rd_end;
   assign w_rd_abort = (r_state == ST_RD_WAIT) && w_timeout;
   assign w_wr_fin   = (r_state == ST_WR_WAIT) && (i_wr_end || w_timeout);
   assign w_gap_done = (r_state == ST_GAP) && (r_gap == GAP_LAST);
   assign w_last     = (r_idx == SCAN_LAST);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (i_enable) begin
               if (i_wr_req)       w_next = ST_WR_ISSUE;
               else if (r_pending) w_next = ST_RD_ISSUE;
            end
         end
         ST_RD_ISSUE: w_next = ST_RD_WAIT;
         ST_RD_WAIT:  if (i_rd_end || w_timeout) w_next = ST_GAP;
         ST_WR_ISSUE: w_next = ST_WR_WAIT;
         ST_WR_WAIT:  if (i_wr_end || w_timeout) w_next = ST_GAP;
         ST_GAP: begin
            if (w_gap_done) begin
               if (!i_enable)      w_next = ST_IDLE;
               else if (i_wr_req)  w_next = ST_WR_ISSUE;
               else if (r_pending) w_next = ST_RD_ISSUE;
               else                w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_pending   <= 1'b0;
         r_gap       <= '0;
         r_wdog      <= '0;
         r_bus_sel   <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_time_we   <= 1'b0;
         r_time_idx  <= '0;
         r_time_data <= '0;
         r_scan_done <= 1'b0;
         r_wr_ack    <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_next;

         r_wdog <= ((r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT)) ? r_wdog + 1'b1 : '0;
         r_gap  <= (r_state == ST_GAP) ? r_gap + 1'b1 : '0;

         if (w_rd_done)       r_idx <= w_last ? '0 : r_idx + 1'b1;
         else if (w_rd_abort) r_idx <= '0;

         // A tick while a scan is pending or running is simply absorbed.
         if ((w_rd_done && w_last) || w_rd_abort) r_pending <= 1'b0;
         else if (w_tick)                         r_pending <= 1'b1;

         // Bus-facing registers only move when an issue state is entered.
         if (w_next == ST_RD_ISSUE) begin
            r_bus_sel <= 1'b0;
            r_addr    <= scan_addr(r_idx);
         end else if (w_next == ST_WR_ISSUE) begin
            r_bus_sel <= 1'b1;
            r_addr    <= i_wr_addr;
            r_wdata   <= i_wr_data;
         end

         r_time_we   <= w_rd_done;
         r_scan_done <= w_rd_done && w_last;
         if (w_rd_done) begin
            r_time_idx  <= r_idx;
            r_time_data <= i_rd_data_in;
         end

         r_wr_ack <= w_wr_fin;

         if (w_timeout)      r_err <= 1'b1;
         else if (i_err_clr) r_err <= 1'b0;
      end
   end

   assign o_rd_start    = (r_state == ST_RD_ISSUE);
   assign o_wr_start    = (r_state == ST_WR_ISSUE);
   assign o_wr_ack      = r_wr_ack;
   assign o_bus_sel     = r_bus_sel;
   assign o_addr_out    = r_addr;
   assign o_wdata_out   = r_wdata;
   assign o_time_we     = r_time_we;
   assign o_time_idx    = r_time_idx;
   assign o_time_data   = r_time_data;
   assign o_scan_done   = r_scan_done;
   assign o_timeout_err = r_err;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Directed bench for rtc_bus_scheduler with behavioural read/write engines.
module tb_rtc_bus_scheduler;

   localparam int unsigned REFRESH = 32;
   localparam int unsigned GAP     = 4;
   localparam int unsigned TMO     = 255;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       wr_req = 1'b0;
   logic [7:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       rd_end = 1'b0;
   logic [7:0] rd_data = '0;
   logic       wr_end = 1'b0;
   logic       err_clr = 1'b0;

   logic       o_wr_ack, o_rd_start, o_wr_start, o_bus_sel;
   logic [7:0] o_addr_out, o_wdata_out, o_time_data;
   logic       o_time_we, o_scan_done, o_timeout_err;
   logic [2:0] o_time_idx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rtc_bus_scheduler #(
      .REFRESH_CYCLES(REFRESH),
      .GAP_CYCLES    (GAP),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_enable     (enable),
      .i_wr_req     (wr_req),
      .i_wr_addr    (wr_addr),
      .i_wr_data    (wr_data),
      .o_wr_ack     (o_wr_ack),
      .o_rd_start   (o_rd_start),
      .i_rd_end     (rd_end),
      .i_rd_data_in (rd_data),
      .o_wr_start   (o_wr_start),
      .i_wr_end     (wr_end),
      .o_bus_sel    (o_bus_sel),
      .o_addr_out   (o_addr_out),
      .o_wdata_out  (o_wdata_out),
      .o_time_we    (o_time_we),
      .o_time_idx   (o_time_idx),
      .o_time_data  (o_time_data),
      .o_scan_done  (o_scan_done),
      .o_timeout_err(o_timeout_err),
      .i_err_clr    (err_clr)
   );

   logic [7:0] tbl [6] = '{8'h00, 8'h02, 8'h04, 8'h07, 8'h08, 8'h09};

   function automatic int idx_of(input logic [7:0] a);
      for (int i = 0; i < 6; i++) if (tbl[i] == a) return i;
      return 15;
   endfunction

   // Read engine: answers 20 cycles after rd_start with 0x10 + table index.
   int         rd_cnt = 0;
   bit         rd_respond = 1'b1;
   logic [7:0] rd_addr_l = '0;
   always @(negedge clk) begin
      rd_end = 1'b0;
      if (!rst_n) begin
         rd_cnt = 0;
      end else begin
         if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               rd_end  = 1'b1;
               rd_data = 8'(16 + idx_of(rd_addr_l));
            end
         end
         if (o_rd_start && rd_respond) begin
            rd_cnt    = 20;
            rd_addr_l = o_addr_out;
         end
      end
   end

   // Write engine: answers 5 cycles after wr_start.
   int wr_cnt = 0;
   bit wr_respond = 1'b1;
   always @(negedge clk) begin
      wr_end = 1'b0;
      if (!rst_n) begin
         wr_cnt = 0;
      end else begin
         if (wr_cnt > 0) begin
            wr_cnt--;
            if (wr_cnt == 0) wr_end = 1'b1;
         end
         if (o_wr_start && wr_respond) wr_cnt = 5;
      end
   end

   // Event log sampled shortly after each rising edge, stamped with a cycle count.
   logic [8:0]  rd_q[$];
   int          rd_t[$];
   logic [10:0] we_q[$];
   int          we_t[$];
   logic [3:0]  done_q[$];
   int          done_t[$];
   logic [16:0] wrs_q[$];
   int          wrs_t[$];
   int          ack_t[$];
   int          mcyc = 0;
   always @(posedge clk) begin
      #2;
      mcyc++;
      if (rst_n) begin
         if (o_rd_start) begin rd_q.push_back({o_bus_sel, o_addr_out}); rd_t.push_back(mcyc); end
         if (o_time_we) begin we_q.push_back({o_time_idx, o_time_data}); we_t.push_back(mcyc); end
         if (o_scan_done) begin done_q.push_back({o_time_we, o_time_idx}); done_t.push_back(mcyc); end
         if (o_wr_start) begin wrs_q.push_back({o_bus_sel, o_addr_out, o_wdata_out}); wrs_t.push_back(mcyc); end
         if (o_wr_ack) ack_t.push_back(mcyc);
      end
   end

   task automatic test_reset();
      logic [39:0] outs;
      rst_n = 1'b0; enable = 1'b1; wr_req = 1'b1; wr_addr = 8'h55; wr_data = 8'hAA;
      repeat (3) @(negedge clk);
      outs = {o_wr_ack, o_rd_start, o_wr_start, o_bus_sel, o_addr_out, o_wdata_out,
              o_time_we, o_time_idx, o_time_data, o_scan_done, o_timeout_err};
      checks++;
      if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", outs); end
      checks++;
      if (o_wr_start !== 1'b0) begin errors++; $display("FAIL reset_wr_start got %b exp 0", o_wr_start); end
      wr_req = 1'b0; enable = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_scan();
      int  n;
      bit  found;
      int  rb, wb, db;
      logic [10:0] exp_we;
      rb = rd_q.size(); wb = we_q.size(); db = done_q.size();
      rst_n = 1'b1; enable = 1'b1;
      n = 0; found = 0;
      while (!found && n < 100) begin @(negedge clk); n++; if (o_rd_start) found = 1; end
      checks++;
      if (!found || n != 33) begin errors++; $display("FAIL first_rd_start got cycle %0d exp 33", n); end
      n = 0;
      while (we_q.size() < wb + 6 && n < 1500) begin @(negedge clk); n++; end
      checks++;
      if (we_q.size() < wb + 6) begin errors++; $display("FAIL scan_wait got %0d writes exp 6", we_q.size() - wb); end
      else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (rd_q[rb+i] !== {1'b0, tbl[i]})
               begin errors++; $display("FAIL scan_addr%0d got %h exp %h", i, rd_q[rb+i], {1'b0, tbl[i]}); end
            exp_we = {3'(i), 8'(16 + i)};
            checks++;
            if (we_q[wb+i] !== exp_we)
               begin errors++; $display("FAIL scan_we%0d got %h exp %h", i, we_q[wb+i], exp_we); end
         end
         checks++;
         if (done_q.size() - db != 1) begin errors++; $display("FAIL scan_done_count got %0d exp 1", done_q.size() - db); end
         else begin
            checks++;
            if (done_q[db] !== {1'b1, 3'd5} || done_t[db] != we_t[wb+5])
               begin errors++; $display("FAIL scan_done_align got %h@%0d exp d@%0d", done_q[db], done_t[db], we_t[wb+5]); end
         end
      end
   endtask

   task automatic test_write_insert();
      int  n;
      bit  found;
      int  rb, wsb, ab;
      rb = rd_q.size();
      n = 0; found = 0;
      while (!found && n < 600) begin
         @(negedge clk); n++;
         if (rd_q.size() > rb && rd_q[rd_q.size()-1][7:0] == 8'h04) found = 1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL wi_wait_idx2 got timeout exp rd_start 04"); end
      repeat (3) @(negedge clk);
      wsb = wrs_q.size(); ab = ack_t.size();
      wr_addr = 8'h0B; wr_data = 8'h86; wr_req = 1'b1;
      n = 0;
      while (wrs_q.size() == wsb && n < 300) begin @(negedge clk); n++; end
      checks++;
      if (wrs_q.size() == wsb) begin errors++; $display("FAIL wi_wr_start got timeout exp wr_start"); end
      else begin
         checks++;
         if (wrs_q[wsb] !== {1'b1, 8'h0B, 8'h86})
            begin errors++; $display("FAIL wi_bus got %h exp 10b86", wrs_q[wsb]); end
         checks++;
         if (we_q[we_q.size()-1] !== {3'd2, 8'h12})
            begin errors++; $display("FAIL wi_prior_read got %h exp 212", we_q[we_q.size()-1]); end
         checks++;
         if (wrs_t[wsb] - we_t[we_t.size()-1] != GAP)
            begin errors++; $display("FAIL wi_gap got %0d exp %0d", wrs_t[wsb] - we_t[we_t.size()-1], GAP); end
      end
      n = 0;
      while (ack_t.size() == ab && n < 100) begin @(negedge clk); n++; end
      wr_req = 1'b0;
      checks++;
      if (ack_t.size() == ab) begin errors++; $display("FAIL wi_ack got timeout exp wr_ack"); end
      else begin
         checks++;
         if (ack_t[ab] - wrs_t[wsb] != 6)
            begin errors++; $display("FAIL wi_ack_lat got %0d exp 6", ack_t[ab] - wrs_t[wsb]); end
      end
      rb = rd_q.size();
      n = 0;
      while (rd_q.size() == rb && n < 300) begin @(negedge clk); n++; end
      checks++;
      if (rd_q.size() == rb || rd_q[rb] !== {1'b0, 8'h07} || rd_t[rb] - ack_t[ab] != GAP)
         begin errors++; $display("FAIL wi_resume got %h exp 007 after gap", (rd_q.size() > rb) ? rd_q[rb] : 9'h1FF); end
   endtask

   task automatic test_timeout();
      int  n;
      bit  found;
      int  db, wb;
      db = done_q.size();
      n = 0;
      while (done_q.size() == db && n < 1000) begin @(negedge clk); n++; end
      checks++;
      if (done_q.size() == db) begin errors++; $display("FAIL to_scan_end got timeout exp scan_done"); end
      rd_respond = 1'b0;
      n = 0; found = 0;
      while (!found && n < 200) begin @(negedge clk); n++; if (o_rd_start) found = 1; end
      checks++;
      if (!found || o_addr_out !== 8'h00) begin errors++; $display("FAIL to_start got %h exp 00", o_addr_out); end
      wb = we_q.size(); db = done_q.size();
      n = 0; found = 0;
      while (!found && n < 400) begin @(negedge clk); n++; if (o_timeout_err) found = 1; end
      rd_respond = 1'b1;
      checks++;
      if (!found || n != 256) begin errors++; $display("FAIL to_latency got %0d exp 256", n); end
      n = 0; found = 0;
      while (!found && n < 200) begin @(negedge clk); n++; if (o_rd_start) found = 1; end
      checks++;
      if (!found || o_addr_out !== 8'h00) begin errors++; $display("FAIL to_restart got %h exp 00", o_addr_out); end
      checks++;
      if (we_q.size() != wb || done_q.size() != db)
         begin errors++; $display("FAIL to_no_write got we %0d done %0d exp 0 0", we_q.size() - wb, done_q.size() - db); end
      checks++;
      if (o_timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", o_timeout_err); end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checks++;
      if (o_timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear got %b exp 0", o_timeout_err); end
   endtask

   task automatic test_reset_in_write();
      int  n;
      bit  found;
      int  ab;
      logic [39:0] outs;
      wr_respond = 1'b0;
      wr_addr = 8'h21; wr_data = 8'h5A; wr_req = 1'b1;
      n = 0; found = 0;
      while (!found && n < 400) begin @(negedge clk); n++; if (o_wr_start) found = 1; end
      checks++;
      if (!found) begin errors++; $display("FAIL rw_wr_start got timeout exp wr_start"); end
      repeat (3) @(negedge clk);
      ab = ack_t.size();
      #2 rst_n = 1'b0;
      #1;
      outs = {o_wr_ack, o_rd_start, o_wr_start, o_bus_sel, o_addr_out, o_wdata_out,
              o_time_we, o_time_idx, o_time_data, o_scan_done, o_timeout_err};
      checks++;
      if (outs !== '0) begin errors++; $display("FAIL rw_async_zero got %h exp 0", outs); end
      wr_respond = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (o_wr_start !== 1'b1 || {o_bus_sel, o_addr_out, o_wdata_out} !== {1'b1, 8'h21, 8'h5A})
         begin errors++; $display("FAIL rw_reissue got %b %h exp 1 1215a", o_wr_start, {o_bus_sel, o_addr_out, o_wdata_out}); end
      checks++;
      if (ack_t.size() != ab) begin errors++; $display("FAIL rw_no_ack got %0d acks exp 0", ack_t.size() - ab); end
      n = 0;
      while (ack_t.size() == ab && n < 50) begin @(negedge clk); n++; end
      wr_req = 1'b0;
      checks++;
      if (ack_t.size() == ab) begin errors++; $display("FAIL rw_ack got timeout exp wr_ack"); end
   endtask

   task automatic test_enable_pause();
      int  n, starts;
      bit  found;
      n = 0; found = 0;
      while (!found && n < 500) begin
         @(negedge clk); n++;
         if (o_rd_start && o_addr_out == 8'h02) found = 1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL ep_wait_idx1 got timeout exp rd_start 02"); end
      repeat (2) @(negedge clk);
      enable = 1'b0;
      n = 0; found = 0;
      while (!found && n < 50) begin @(negedge clk); n++; if (o_time_we) found = 1; end
      checks++;
      if (!found || {o_time_idx, o_time_data} !== {3'd1, 8'h11})
         begin errors++; $display("FAIL ep_read_done got %h exp 111", {o_time_idx, o_time_data}); end
      starts = 0;
      for (int i = 0; i < 60; i++) begin @(negedge clk); if (o_rd_start) starts++; end
      checks++;
      if (starts != 0 || o_bus_sel !== 1'b0 || o_addr_out !== 8'h02)
         begin errors++; $display("FAIL ep_parked got %0d starts addr %h exp 0 starts addr 02", starts, o_addr_out); end
      enable = 1'b1;
      n = 0; found = 0;
      while (!found && n < 40) begin @(negedge clk); n++; if (o_rd_start) found = 1; end
      checks++;
      if (!found || n != 1 || o_addr_out !== 8'h04)
         begin errors++; $display("FAIL ep_resume got addr %h after %0d exp 04 after 1", o_addr_out, n); end
   endtask

   task automatic test_refresh_drop();
      int n;
      int rb, wb, db;
      db = done_q.size();
      n = 0;
      while (done_q.size() == db && n < 1000) begin @(negedge clk); n++; end
      checks++;
      if (done_q.size() == db) begin errors++; $display("FAIL rd_first_done got timeout exp scan_done"); end
      rb = rd_q.size(); wb = we_q.size(); db = done_q.size();
      n = 0;
      while (done_q.size() == db && n < 1000) begin @(negedge clk); n++; end
      repeat (GAP + 2) @(negedge clk);
      checks++;
      if (rd_q.size() - rb != 6 || we_q.size() - wb != 6 || done_q.size() - db != 1)
         begin errors++; $display("FAIL rd_one_scan got rd %0d we %0d done %0d exp 6 6 1",
                                  rd_q.size() - rb, we_q.size() - wb, done_q.size() - db); end
      else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (rd_q[rb+i] !== {1'b0, tbl[i]})
               begin errors++; $display("FAIL rd_addr%0d got %h exp %h", i, rd_q[rb+i], {1'b0, tbl[i]}); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_write_insert();
      test_timeout();
      test_reset_in_write();
      test_enable_pause();
      test_refresh_drop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
